// File: rtl/i2s_pkg.sv
// Shared types, constants and parameter-legality helpers for the I2S receiver.
package i2s_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2
    } i2s_rx_state_t;

    localparam int ERR_CNT_W = 8;

    function automatic bit data_w_legal(input int data_w);
        return (data_w >= 8) && (data_w <= 32);
    endfunction

    function automatic bit slot_w_legal(input int data_w, input int slot_w);
        return (slot_w >= data_w) && (slot_w <= 64);
    endfunction

    function automatic bit cfg_legal(input int data_w, input int slot_w, input int lj_mode);
        return data_w_legal(data_w) && slot_w_legal(data_w, slot_w) &&
               ((lj_mode == 0) || (lj_mode == 1));
    endfunction

    // One spare code so the saturation value SLOT_W+1 always fits.
    function automatic int cnt_width(input int slot_w);
        return $clog2(slot_w + 2);
    endfunction

endpackage

// File: rtl/i2s_rx_frm_if.sv
// Pin-side inputs and sample-side outputs of the I2S receiver.
interface i2s_rx_frm_if #(
    parameter int DATA_W = 24
);
    import i2s_pkg::*;

    logic                 I2S_sclk;
    logic                 I2S_ws;
    logic                 I2S_data;
    logic [DATA_W-1:0]    lft_chnnl;
    logic [DATA_W-1:0]    rght_chnnl;
    logic                 vld;
    logic                 locked;
    logic                 sync_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output I2S_sclk, I2S_ws, I2S_data,
        input  lft_chnnl, rght_chnnl, vld, locked, sync_err, err_cnt
    );

    modport slave (
        input  I2S_sclk, I2S_ws, I2S_data,
        output lft_chnnl, rght_chnnl, vld, locked, sync_err, err_cnt
    );

endinterface

// File: rtl/i2s_pin_sync.sv
// Three matched 3-flop synchronisers for sclk/ws/data plus sclk rise detect.
module i2s_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_i,
    input  logic ws_i,
    input  logic data_i,
    output logic bit_evt_o,
    output logic ws_s_o,
    output logic data_s_o
);

    localparam int N_PINS = 3;
    // Bit order {data, ws, sclk}: ws idles high so the chain resets to 1.
    localparam logic [N_PINS-1:0] RST_VAL = 3'b010;

    logic [N_PINS-1:0] pin_in;
    logic [N_PINS-1:0] stage2;
    logic [N_PINS-1:0] stage3;
    logic              unused_stage3;

    assign pin_in = {data_i, ws_i, sclk_i};

    generate
        for (genvar gi = 0; gi < N_PINS; gi++) begin : g_chain
            logic [2:0] sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= {3{RST_VAL[gi]}};
                end else begin
                    sync_q <= {sync_q[1:0], pin_in[gi]};
                end
            end

            assign stage2[gi] = sync_q[1];
            assign stage3[gi] = sync_q[2];
        end
    endgenerate

    assign bit_evt_o     = stage2[0] & ~stage3[0];
    assign ws_s_o        = stage2[1];
    assign data_s_o      = stage2[2];
    assign unused_stage3 = &{1'b0, stage3[2:1]};

endmodule

// File: rtl/i2s_rx_frm.sv
// I2S receiver: slot framing check, per-channel capture and sample-pair output.
module i2s_rx_frm
    import i2s_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32,
    parameter int LJ_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    i2s_rx_frm_if.slave bus
);

    localparam int                   CNT_W    = cnt_width(SLOT_W);
    localparam logic [CNT_W-1:0]     SLOT_CNT = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(SLOT_W + 1);
    localparam logic [CNT_W-1:0]     DATA_CNT = CNT_W'(DATA_W);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    generate
        if (!cfg_legal(DATA_W, SLOT_W, LJ_MODE)) begin : g_bad_cfg
            $error("i2s_rx_frm: illegal DATA_W/SLOT_W/LJ_MODE combination");
        end
    endgenerate

    logic bit_evt;
    logic ws_s;
    logic data_s;

    i2s_pin_sync u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk_i    (bus.I2S_sclk),
        .ws_i      (bus.I2S_ws),
        .data_i    (bus.I2S_data),
        .bit_evt_o (bit_evt),
        .ws_s_o    (ws_s),
        .data_s_o  (data_s)
    );

    logic                  prev_ws_q;
    logic                  prev_ch_q;
    logic                  ch;
    logic                  boundary;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    i2s_rx_state_t         state_q, state_d;
    logic                  vld_q, vld_d;
    logic                  locked_q, locked_d;
    logic                  sync_err_q, sync_err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]     lft_q, rght_q;
    logic [1:0][DATA_W-1:0] sr;
    logic                  slot_full;
    logic                  slot_err;

    // Standard I2S tags each bit with the ws seen one bit earlier.
    assign ch        = (LJ_MODE != 0) ? ws_s : prev_ws_q;
    assign boundary  = bit_evt && (ch != prev_ch_q);
    assign slot_full = (bit_cnt_q == SLOT_CNT);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (boundary) begin
            bit_cnt_d = CNT_W'(1);
        end else if (bit_evt && (bit_cnt_q != CNT_SAT)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sreg
            logic [DATA_W-1:0] sr_q;
            logic              shift_en;

            assign shift_en = bit_evt && (ch == 1'(gi)) &&
                              (boundary || (bit_cnt_q < DATA_CNT));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_q <= '0;
                end else if (shift_en) begin
                    sr_q <= {sr_q[DATA_W-2:0], data_s};
                end
            end

            assign sr[gi] = sr_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        vld_d      = 1'b0;
        sync_err_d = 1'b0;
        locked_d   = locked_q;
        err_cnt_d  = err_cnt_q;
        slot_err   = 1'b0;

        case (state_q)
            UNSYNC: begin
                if (boundary && !ch) state_d = LEFT;
            end
            LEFT: begin
                if (boundary) begin
                    if (ch && slot_full) state_d = RIGHT;
                    else                 slot_err = 1'b1;
                end else if (bit_evt && slot_full) begin
                    slot_err = 1'b1;
                end
            end
            RIGHT: begin
                if (boundary) begin
                    if (!ch && slot_full) begin
                        state_d  = LEFT;
                        vld_d    = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        slot_err = 1'b1;
                    end
                end else if (bit_evt && slot_full) begin
                    slot_err = 1'b1;
                end
            end
            default: state_d = UNSYNC;
        endcase

        // A wrong-length slot always drops back to hunting for a left boundary.
        if (slot_err) begin
            state_d    = UNSYNC;
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ws_q  <= 1'b1;
            prev_ch_q  <= 1'b0;
            bit_cnt_q  <= '0;
            state_q    <= UNSYNC;
            vld_q      <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
            err_cnt_q  <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
        end else begin
            if (bit_evt) begin
                prev_ws_q <= ws_s;
                prev_ch_q <= ch;
            end
            bit_cnt_q  <= bit_cnt_d;
            state_q    <= state_d;
            vld_q      <= vld_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
            err_cnt_q  <= err_cnt_d;
            if (vld_d) begin
                lft_q  <= sr[0];
                rght_q <= sr[1];
            end
        end
    end

    assign bus.lft_chnnl  = lft_q;
    assign bus.rght_chnnl = rght_q;
    assign bus.vld        = vld_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule
